sw_rd_burst_splitter: RTL
=========================

// Module: sw_rd_burst_splitter
// PURPOSE
//  Sits between an Engine's reference-fetch logic and one AXIArbiter read port (rd_*_N).
//  Turns one long read request (address + beat count) into legal AXI bursts.
//  Bursts are capped at MAX_BURST and never cross a 4KB boundary.
//  Outstanding beats are bounded by a credit counter so the Engine's ref FIFO cannot overflow.
//  Read data passes straight through; beats are counted and a done pulse ends each request.
// PARAMETERS
//  ADDR_W        33   byte address width
//  DATA_W        256  data beat width (32 B/beat)
//  ID_W          6    AXI read ID width
//  LEN_W         16   request beat-count width
//  MAX_BURST     64   max beats per burst; power of 2, 1..256
//  CREDIT_BEATS  128  max beats issued but not yet consumed; >= MAX_BURST
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       asynchronous reset, active-low
//  req_addr_in      in   ADDR_W  start byte address; bits[4:0] forced to 0
//  req_beats_in     in   LEN_W   total beats requested
//  req_id_in        in   ID_W    ID placed on every burst of this request
//  req_valid_in     in   1       request valid
//  req_rdy_out      out  1       request accepted when valid&rdy
//  rd_id_out        out  ID_W    burst ID to arbiter
//  rd_addr_out      out  ADDR_W  burst address to arbiter
//  rd_len_out       out  8       AXI len (beats-1)
//  rd_info_valid_out out 1       burst valid
//  rd_info_rdy_in   in   1       arbiter accepts burst
//  rd_data_in       in   DATA_W  read data from arbiter
//  rd_data_valid_in in   1       read data valid from arbiter
//  rd_data_rdy_out  out  1       = data_rdy_in (combinational)
//  data_out         out  DATA_W  = rd_data_in (combinational)
//  data_valid_out   out  1       = rd_data_valid_in (combinational)
//  data_rdy_in      in   1       consumer ready
//  done_out         out  1       one-cycle pulse: all beats of current request consumed
// BEHAVIOUR
//  Reset: req_rdy_out=0, rd_info_valid_out=0, rd_id/addr/len=0, done_out=0.
//   Internally: credits=CREDIT_BEATS, state=IDLE.
//  FSM:
//   IDLE: req_rdy_out=1. On accept, latch addr/beats/id; remaining=beats, rcvd=0.
//    beats==0 -> done_out pulses the next cycle and the FSM stays IDLE (no burst).
//    beats>0  -> ISSUE.
//   ISSUE: size = min(remaining, MAX_BURST, 128 - addr[11:5]).
//    If credits >= size: assert rd_info_valid_out, rd_len_out=size-1.
//    Otherwise hold rd_info_valid_out low until credits >= size.
//    On handshake: addr += size*32, remaining -= size, credits -= size.
//    remaining==0 after the handshake -> DRAIN; else the next burst is valid the next cycle (no bubble).
//   DRAIN: wait until rcvd==beats, then done_out=1 for one cycle -> IDLE.
//  Latency: request accepted in cycle N -> first rd_info_valid_out in cycle N+1.
//  Once rd_info_valid_out is high, it and id/addr/len are held stable until rd_info_rdy_in.
//  Beat consumed = rd_data_valid_in & data_rdy_in. Each consumed beat: credits += 1, rcvd += 1.
//   Applies in ISSUE and DRAIN.
//  Same-cycle burst handshake and beat consumed: credits = credits - size + 1.
//  Credits saturate at CREDIT_BEATS.
//  Beats consumed in IDLE (unsolicited) pass through but are not counted.
//  rcvd never exceeds beats; extra beats in DRAIN are ignored for counting.
//  The 4KB rule uses byte address bits[11:5]; the address carries across bit 12 normally.
//  Reset asserted mid-request: the request is abandoned, all state cleared; no done_out.
// CONFIGURATION
//  SW_SPLIT_STATS_EN defined: adds outputs
//   stat_bursts_out[31:0] = bursts issued (handshakes)
//   stat_stall_out[31:0]  = cycles in ISSUE with valid low because of credits
//   Both wrap at 2^32 and are cleared only by reset.
//  Not defined: no stat ports, no counters.
// STRUCTURE
//  Shared package sw_axi_pkg: BYTES_PER_BEAT=32, BOUNDARY_BEATS=128,
//   FSM state enum {IDLE,ISSUE,DRAIN}, AXI len width 8.
//  Single module; burst-size min() logic as function sw_burst_size in the package.
//  No sub-module.
// TESTING
//  1. addr=0x0, beats=64, MAX_BURST=64, rdy=1
//     -> one burst len=63 addr=0x0; done after 64th beat.
//  2. addr=0xFC0 (beat 126 of page), beats=10
//     -> bursts addr=0xFC0 len=1, then addr=0x1000 len=7.
//  3. beats=300, CREDIT_BEATS=128, data_rdy_in=0
//     -> bursts 64,64 then valid held low; raising data_rdy_in for 64 beats releases burst 3.
//  4. beats=0 -> req accepted, done_out one cycle later, no rd_info_valid_out.
//  5. rd_info_rdy_in low 5 cycles -> valid/addr/len stable throughout.
//     Same-cycle handshake and beat -> credits net correct.
//  6. rst_n low mid-DRAIN -> all outputs to reset values, no done_out.
//     Next request behaves as a fresh one.

Source files
------------

// File: rtl/sw_axi_pkg.sv
// Shared constants, FSM state type and burst-size helper for the read burst splitter.
package sw_axi_pkg;

  localparam int BYTES_PER_BEAT = 32;
  localparam int BOUNDARY_BEATS = 128;
  localparam int AXI_LEN_W      = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} sw_state_e;

  // Largest legal burst: bounded by beats left, the burst cap and the room left in the 4KB page.
  function automatic logic [8:0] sw_burst_size(input logic [31:0] remaining,
                                               input logic [6:0]  page_beat,
                                               input logic [31:0] max_burst);
    logic [31:0] room;
    logic [31:0] size;
    room = 32'(BOUNDARY_BEATS) - {25'd0, page_beat};
    size = remaining;
    if (max_burst < size) size = max_burst;
    if (room < size) size = room;
    return 9'(size);
  endfunction

endpackage

// File: rtl/sw_rd_burst_splitter.sv
// Splits one long read request into credit-limited AXI bursts that never cross 4KB.
// Optional build macro SW_SPLIT_STATS_EN adds burst and credit-stall counters.
module sw_rd_burst_splitter
  import sw_axi_pkg::*;
#(
  parameter int ADDR_W       = 33,
  parameter int DATA_W       = 256,
  parameter int ID_W         = 6,
  parameter int LEN_W        = 16,
  parameter int MAX_BURST    = 64,
  parameter int CREDIT_BEATS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    req_addr_in,
  input  logic [LEN_W-1:0]     req_beats_in,
  input  logic [ID_W-1:0]      req_id_in,
  input  logic                 req_valid_in,
  output logic                 req_rdy_out,
  output logic [ID_W-1:0]      rd_id_out,
  output logic [ADDR_W-1:0]    rd_addr_out,
  output logic [7:0]           rd_len_out,
  output logic                 rd_info_valid_out,
  input  logic                 rd_info_rdy_in,
  input  logic [DATA_W-1:0]    rd_data_in,
  input  logic                 rd_data_valid_in,
  output logic                 rd_data_rdy_out,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid_out,
  input  logic                 data_rdy_in,
`ifdef SW_SPLIT_STATS_EN
  output logic [31:0]          stat_bursts_out,
  output logic [31:0]          stat_stall_out,
`endif
  output logic                 done_out
);

  localparam int CRED_W = $clog2(CREDIT_BEATS + 1);

  sw_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      beats_q, beats_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic [LEN_W-1:0]      rcvd_q, rcvd_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [CRED_W-1:0]     credits_q, credits_d;
  logic [AXI_LEN_W-1:0]  len_q, len_d;
  logic                  valid_q, valid_d;
  logic                  req_rdy_q, req_rdy_d;
  logic                  done_q, done_d;
  logic [8:0]            size_cur, size_next;
  logic [31:0]           credit_sum;
  logic                  accept, burst_hs, beat_cons;

  assign size_cur  = sw_burst_size(32'(remaining_q), addr_q[11:5], 32'(MAX_BURST));
  assign accept    = req_valid_in & req_rdy_q;
  assign burst_hs  = valid_q & rd_info_rdy_in;
  assign beat_cons = rd_data_valid_in & data_rdy_in & (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    remaining_d = remaining_q;
    rcvd_d      = rcvd_q;
    id_d        = id_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d      = req_addr_in & ~ADDR_W'(BYTES_PER_BEAT - 1);
          beats_d     = req_beats_in;
          remaining_d = req_beats_in;
          rcvd_d      = '0;
          id_d        = req_id_in;
          if (req_beats_in == '0) done_d = 1'b1;
          else                    state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (burst_hs) begin
          addr_d      = addr_q + ADDR_W'(size_cur) * ADDR_W'(BYTES_PER_BEAT);
          remaining_d = remaining_q - LEN_W'(size_cur);
          if (remaining_d == '0) state_d = DRAIN;
        end
      end
      default: ;
    endcase

    // Beats beyond the requested count are passed through but not counted.
    if (beat_cons && (rcvd_q != beats_q)) rcvd_d = rcvd_q + LEN_W'(1);

    credit_sum = 32'(credits_q) - (burst_hs ? 32'(size_cur) : 32'd0)
               + (beat_cons ? 32'd1 : 32'd0);
    credits_d  = (credit_sum > 32'(CREDIT_BEATS)) ? CRED_W'(CREDIT_BEATS) : CRED_W'(credit_sum);

    if ((state_q == DRAIN) && (rcvd_d == beats_q)) begin
      done_d  = 1'b1;
      state_d = IDLE;
    end

    // Outputs are registered from next-state values so the next burst follows without a bubble.
    size_next = sw_burst_size(32'(remaining_d), addr_d[11:5], 32'(MAX_BURST));
    valid_d   = (state_d == ISSUE) && (32'(credits_d) >= 32'(size_next));
    len_d     = (state_d == ISSUE) ? AXI_LEN_W'(size_next - 9'd1) : '0;
    req_rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      remaining_q <= '0;
      rcvd_q      <= '0;
      id_q        <= '0;
      credits_q   <= CRED_W'(CREDIT_BEATS);
      len_q       <= '0;
      valid_q     <= 1'b0;
      req_rdy_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      remaining_q <= remaining_d;
      rcvd_q      <= rcvd_d;
      id_q        <= id_d;
      credits_q   <= credits_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      req_rdy_q   <= req_rdy_d;
      done_q      <= done_d;
    end
  end

  assign req_rdy_out       = req_rdy_q;
  assign rd_id_out         = id_q;
  assign rd_addr_out       = addr_q;
  assign rd_len_out        = len_q;
  assign rd_info_valid_out = valid_q;
  assign done_out          = done_q;
  assign rd_data_rdy_out   = data_rdy_in;
  assign data_out          = rd_data_in;
  assign data_valid_out    = rd_data_valid_in;

`ifdef SW_SPLIT_STATS_EN
  logic [31:0] stat_bursts_q, stat_bursts_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_bursts_d = stat_bursts_q + (burst_hs ? 32'd1 : 32'd0);
    stat_stall_d  = stat_stall_q + (((state_q == ISSUE) && !valid_q) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bursts_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_bursts_q <= stat_bursts_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_bursts_out = stat_bursts_q;
  assign stat_stall_out  = stat_stall_q;
`endif

endmodule
